// File: rtl/memory_be_init.sv
// memory_be_init: single-port synchronous memory with per-byte write enables,
// a 1..3 cycle fully pipelined read path and a hardware init/clear engine that
// fills every word with INIT_VAL after reset or on a clr_i request.
// Requests use a valid/ready handshake; one request can be accepted per cycle.
module memory_be_init #(
  parameter int                WIDTH      = 16,
  parameter int                DEPTH      = 64,
  parameter int                ADDR_WIDTH = $clog2(DEPTH),
  parameter int                RD_LAT     = 1,
  parameter logic [WIDTH-1:0]  INIT_VAL   = {WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic [WIDTH/8-1:0]    be_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  clr_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int NBYTES = WIDTH / 8;

  // Address bound widened by one bit so DEPTH itself is representable even
  // when DEPTH is an exact power of two.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_READY = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   cnt_r;
  logic                    busy_r;
  logic                    err_r;

  logic [WIDTH-1:0]        mem_r [DEPTH];

  logic [RD_LAT-1:0]       pipe_vld_r;
  logic [WIDTH-1:0]        pipe_dat_r [RD_LAT];

  logic                    ready_s;
  logic                    accept_s;
  logic                    rd_accept_s;
  logic                    in_range_s;
  logic                    fill_we_s;
  logic                    user_we_s;
  logic [WIDTH-1:0]        rd_word_s;

  // Handshake decode, range check and array read for the accepting cycle.
  always_comb begin
    ready_s     = 1'b0;
    accept_s    = 1'b0;
    rd_accept_s = 1'b0;
    in_range_s  = 1'b0;
    fill_we_s   = 1'b0;
    user_we_s   = 1'b0;
    rd_word_s   = {WIDTH{1'b0}};

    // clr_i takes priority over a same-cycle request, so ready drops at once.
    if (state_r == ST_READY) begin
      ready_s = !clr_i;
    end else begin
      ready_s = 1'b0;
    end

    accept_s    = valid_i && ready_s;
    rd_accept_s = accept_s && !wr_rd_i;
    in_range_s  = ({1'b0, addr_i} < DEPTH_EXT);

    // The first cycle after reset only arms busy_r; fill writes start after.
    if ((state_r != ST_READY) && busy_r) begin
      fill_we_s = 1'b1;
    end else begin
      fill_we_s = 1'b0;
    end

    user_we_s = accept_s && wr_rd_i && in_range_s;

    // Out-of-range reads return zero instead of touching the array.
    if (in_range_s) begin
      rd_word_s = mem_r[addr_i];
    end else begin
      rd_word_s = {WIDTH{1'b0}};
    end
  end

  // Control FSM: INIT after reset, READY for traffic, CLEAR on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_INIT;
      cnt_r   <= {ADDR_WIDTH{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT, ST_CLEAR: begin
          if (!busy_r) begin
            busy_r <= 1'b1;
          end else if (cnt_r == LAST_ADDR) begin
            state_r <= ST_READY;
            busy_r  <= 1'b0;
            cnt_r   <= {ADDR_WIDTH{1'b0}};
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_READY: begin
          if (clr_i) begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
            cnt_r   <= {ADDR_WIDTH{1'b0}};
          end else begin
            busy_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_INIT;
          busy_r  <= 1'b0;
          cnt_r   <= {ADDR_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Storage array: fill-engine writes or byte-masked user writes; no reset.
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      mem_r[cnt_r] <= INIT_VAL;
    end else if (user_we_s) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (be_i[k]) begin
          mem_r[addr_i][8*k +: 8] <= wr_data_i[8*k +: 8];
        end
      end
    end
  end

  // Read return pipeline; each stage's data only moves with a valid token so
  // the output word holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_r <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_dat_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      pipe_vld_r[0] <= rd_accept_s;
      if (rd_accept_s) begin
        pipe_dat_r[0] <= rd_word_s;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        if (pipe_vld_r[i-1]) begin
          pipe_dat_r[i] <= pipe_dat_r[i-1];
        end
      end
    end
  end

  // Error pulse for any accepted request that addresses beyond the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= accept_s && !in_range_s;
    end
  end

  assign ready_o    = ready_s;
  assign busy_o     = busy_r;
  assign err_o      = err_r;
  assign rd_valid_o = pipe_vld_r[RD_LAT-1];
  assign rd_data_o  = pipe_dat_r[RD_LAT-1];

endmodule

// File: tb/tb_memory_be_init.sv
// Directed bench for memory_be_init. Three instances share one stimulus bus:
// u_a (DEPTH 64, RD_LAT 1), u_b (DEPTH 64, RD_LAT 3), u_c (DEPTH 48, RD_LAT 1).
module tb_memory_be_init;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, wr_rd_i, clr_i;
  logic [5:0]  addr_i;
  logic [15:0] wr_data_i;
  logic [1:0]  be_i;

  logic        ready_a, rd_valid_a, busy_a, err_a;
  logic [15:0] rd_data_a;
  logic        ready_b, rd_valid_b, busy_b, err_b;
  logic [15:0] rd_data_b;
  logic        ready_c, rd_valid_c, busy_c, err_c;
  logic [15:0] rd_data_c;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q_a[$], q_b[$], q_c[$], e64[$], e48[$];
  logic [15:0] m64 [64];
  logic [15:0] m48 [48];
  int err_cnt_a = 0, err_cnt_c = 0, vld_cnt_b = 0, run_b = 0, max_run_b = 0;

  memory_be_init #(.WIDTH(16), .DEPTH(64), .RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_a),
    .wr_rd_i(wr_rd_i), .addr_i(addr_i), .wr_data_i(wr_data_i), .be_i(be_i),
    .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a), .clr_i(clr_i),
    .busy_o(busy_a), .err_o(err_a));

  memory_be_init #(.WIDTH(16), .DEPTH(64), .RD_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_b),
    .wr_rd_i(wr_rd_i), .addr_i(addr_i), .wr_data_i(wr_data_i), .be_i(be_i),
    .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b), .clr_i(clr_i),
    .busy_o(busy_b), .err_o(err_b));

  memory_be_init #(.WIDTH(16), .DEPTH(48), .RD_LAT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_c),
    .wr_rd_i(wr_rd_i), .addr_i(addr_i), .wr_data_i(wr_data_i), .be_i(be_i),
    .rd_data_o(rd_data_c), .rd_valid_o(rd_valid_c), .clr_i(clr_i),
    .busy_o(busy_c), .err_o(err_c));

  // 10-unit clock.
  always #5 clk = ~clk;

  // Collect read returns and error pulses away from the active edge.
  always @(negedge clk) begin
    if (rd_valid_a) q_a.push_back(rd_data_a);
    if (rd_valid_b) begin
      q_b.push_back(rd_data_b);
      vld_cnt_b++;
      run_b++;
      if (run_b > max_run_b) max_run_b = run_b;
    end else begin
      run_b = 0;
    end
    if (rd_valid_c) q_c.push_back(rd_data_c);
    if (err_a) err_cnt_a++;
    if (err_c) err_cnt_c++;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic zero_models();
    for (int i = 0; i < 64; i++) m64[i] = 16'h0000;
    for (int i = 0; i < 48; i++) m48[i] = 16'h0000;
  endtask

  task automatic wr(int addr, logic [15:0] d, logic [1:0] be);
    for (int k = 0; k < 2; k++) begin
      if (be[k]) begin
        m64[addr][8*k +: 8] = d[8*k +: 8];
        if (addr < 48) m48[addr][8*k +: 8] = d[8*k +: 8];
      end
    end
    valid_i = 1'b1; wr_rd_i = 1'b1; addr_i = 6'(addr); wr_data_i = d; be_i = be;
    @(negedge clk);
    valid_i = 1'b0; wr_rd_i = 1'b0; be_i = 2'b00;
  endtask

  task automatic rd(int addr);
    e64.push_back(m64[addr]);
    if (addr < 48) e48.push_back(m48[addr]);
    else           e48.push_back(16'h0000);
    valid_i = 1'b1; wr_rd_i = 1'b0; addr_i = 6'(addr);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic clear_queues();
    q_a.delete(); q_b.delete(); q_c.delete(); e64.delete(); e48.delete();
  endtask

  task automatic drain_check(string tag);
    repeat (6) @(negedge clk);
    check({tag, "_na"}, q_a.size(), e64.size());
    check({tag, "_nb"}, q_b.size(), e64.size());
    check({tag, "_nc"}, q_c.size(), e48.size());
    for (int i = 0; i < e64.size() && i < q_a.size(); i++)
      check($sformatf("%s_a[%0d]", tag, i), q_a[i], e64[i]);
    for (int i = 0; i < e64.size() && i < q_b.size(); i++)
      check($sformatf("%s_b[%0d]", tag, i), q_b[i], e64[i]);
    for (int i = 0; i < e48.size() && i < q_c.size(); i++)
      check($sformatf("%s_c[%0d]", tag, i), q_c[i], e48[i]);
    clear_queues();
  endtask

  // Counts negedges with busy_a high; stops on the first low after a high.
  task automatic count_busy(output int n, output int bad);
    n = 0; bad = 0;
    for (int g = 0; g < 300; g++) begin
      if (busy_a) begin
        n++;
        if (ready_a) bad++;
      end else if (n > 0) begin
        break;
      end
      @(negedge clk);
    end
  endtask

  // Hard stop in case something stalls outside the bounded loops.
  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, vb0;
    rst_n = 1'b0; valid_i = 1'b0; wr_rd_i = 1'b0; clr_i = 1'b0;
    addr_i = 6'd0; wr_data_i = 16'h0000; be_i = 2'b00;
    zero_models();

    // Reset state
    #23;
    check("rst_ready", ready_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_rvalid", rd_valid_a, 1'b0);
    check("rst_rdata", rd_data_a, 16'h0000);
    check("rst_err", err_a, 1'b0);

    // INIT after release: busy for exactly DEPTH cycles
    @(negedge clk); rst_n = 1'b1;
    count_busy(n, bad);
    check("init_busy_cycles", n, 64);
    check("init_ready_low", bad, 0);
    check("init_ready_after", ready_a, 1'b1);
    check("init_c_ready", ready_c, 1'b1);
    check("init_c_busy", busy_c, 1'b0);

    // Sweep every address: all zero; u_c flags 48..63
    for (int i = 0; i < 64; i++) rd(i);
    drain_check("sweep");
    check("sweep_err_c", err_cnt_c, 16);
    check("sweep_err_a", err_cnt_a, 0);

    // Full write then read-after-write on the next cycle
    wr(3, 16'hA5A5, 2'b11);
    rd(3);
    check("t2_vld_a", rd_valid_a, 1'b1);
    check("t2_dat_a", rd_data_a, 16'hA5A5);
    check("t2_vld_b_early", rd_valid_b, 1'b0);
    @(negedge clk);
    check("t2_hold_vld_a", rd_valid_a, 1'b0);
    check("t2_hold_dat_a", rd_data_a, 16'hA5A5);
    check("t2_vld_b_mid", rd_valid_b, 1'b0);
    @(negedge clk);
    check("t2_vld_b", rd_valid_b, 1'b1);
    check("t2_dat_b", rd_data_b, 16'hA5A5);
    drain_check("t2");

    // Byte enables
    wr(3, 16'h1234, 2'b01);
    rd(3);
    check("t3_be01", rd_data_a, 16'hA534);
    wr(3, 16'hFFFF, 2'b00);
    rd(3);
    check("t3_be00", rd_data_a, 16'hA534);
    drain_check("t3");

    // Back-to-back stream through the 3-deep pipeline
    max_run_b = 0;
    wr(5, 16'hBEEF, 2'b11);
    rd(5);
    for (int i = 0; i < 64; i++) rd(i);
    drain_check("t4");
    check("t4_run_b", max_run_b, 65);

    // Clear taken while reads are in flight
    for (int i = 0; i < 6; i++) rd(i);
    clr_i = 1'b1; valid_i = 1'b1; wr_rd_i = 1'b0; addr_i = 6'd6;
    #1;
    check("t5_ready_on_clr", ready_a, 1'b0);
    @(negedge clk);
    clr_i = 1'b0; valid_i = 1'b0;
    count_busy(n, bad);
    check("clr_busy_cycles", n, 64);
    check("clr_ready_low", bad, 0);
    check("clr_ready_after", ready_a, 1'b1);
    drain_check("t5_inflight");
    zero_models();
    rd(3); rd(5);
    drain_check("t5_post");

    // Reset in the middle of CLEAR
    wr(60, 16'h6060, 2'b11);
    wr(3, 16'h1111, 2'b11);
    rd(3);
    check("t5r_dat_before", rd_data_a, 16'h1111);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    repeat (10) @(negedge clk);
    check("t5r_busy_mid", busy_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5r_ready", ready_a, 1'b0);
    check("t5r_busy", busy_a, 1'b0);
    check("t5r_rvalid", rd_valid_a, 1'b0);
    check("t5r_rdata", rd_data_a, 16'h0000);
    check("t5r_err", err_a, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    zero_models();
    clear_queues();
    count_busy(n, bad);
    check("t5r_init_cycles", n, 64);
    check("t5r_ready_after", ready_a, 1'b1);
    rd(60); rd(3);
    drain_check("t5r_post");

    // Reset while a 3-cycle read is in flight: no return
    vb0 = vld_cnt_b;
    valid_i = 1'b1; wr_rd_i = 1'b0; addr_i = 6'd7;
    @(negedge clk);
    valid_i = 1'b0;
    #2 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("midread_discard_b", vld_cnt_b - vb0, 0);
    rst_n = 1'b1;
    count_busy(n, bad);
    check("midread_init_cycles", n, 64);
    clear_queues();
    zero_models();

    // Out-of-range on the 48-deep instance
    wr(2, 16'h2222, 2'b11);
    rd(2);
    wr(50, 16'h7777, 2'b11);
    check("t6_wr_err_c", err_c, 1'b1);
    check("t6_wr_err_a", err_a, 1'b0);
    @(negedge clk);
    check("t6_err_c_pulse", err_c, 1'b0);
    rd(50);
    check("t6_rd_vld_c", rd_valid_c, 1'b1);
    check("t6_rd_dat_c", rd_data_c, 16'h0000);
    check("t6_rd_err_c", err_c, 1'b1);
    check("t6_rd_dat_a", rd_data_a, 16'h7777);
    rd(2);
    drain_check("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
